// File: rtl/pipe_regs.sv
// F, D and E pipeline registers for the Y86-64 five-stage core, with stall/bubble
// handling, saturating hazard-event counters and a sticky stall/bubble conflict flag.
module pipe_regs #(
    parameter int unsigned W  = 64,
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          F_stall,
    input  logic          D_stall,
    input  logic          D_bubble,
    input  logic          E_bubble,
    input  logic [W-1:0]  f_predPC,
    input  logic [1:0]    f_stat,
    input  logic [3:0]    f_icode,
    input  logic [3:0]    f_ifun,
    input  logic [3:0]    f_rA,
    input  logic [3:0]    f_rB,
    input  logic [W-1:0]  f_valC,
    input  logic [W-1:0]  f_valP,
    input  logic [1:0]    d_stat,
    input  logic [3:0]    d_icode,
    input  logic [3:0]    d_ifun,
    input  logic [W-1:0]  d_valC,
    input  logic [W-1:0]  d_valA,
    input  logic [W-1:0]  d_valB,
    input  logic [3:0]    d_dstE,
    input  logic [3:0]    d_dstM,
    input  logic [3:0]    d_srcA,
    input  logic [3:0]    d_srcB,
    output logic [W-1:0]  F_predPC,
    output logic [1:0]    D_stat,
    output logic [3:0]    D_icode,
    output logic [3:0]    D_ifun,
    output logic [3:0]    D_rA,
    output logic [3:0]    D_rB,
    output logic [W-1:0]  D_valC,
    output logic [W-1:0]  D_valP,
    output logic [1:0]    E_stat,
    output logic [3:0]    E_icode,
    output logic [3:0]    E_ifun,
    output logic [W-1:0]  E_valC,
    output logic [W-1:0]  E_valA,
    output logic [W-1:0]  E_valB,
    output logic [3:0]    E_dstE,
    output logic [3:0]    E_dstM,
    output logic [3:0]    E_srcA,
    output logic [3:0]    E_srcB,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] bubble_cnt,
    output logic          ctl_conflict
);

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] R_NONE   = 4'hF;

    logic [CW-1:0] cnt_max;
    assign cnt_max = {CW{1'b1}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F_predPC     <= '0;
            D_stat       <= STAT_AOK;
            D_icode      <= I_NOP;
            D_ifun       <= 4'h0;
            D_rA         <= R_NONE;
            D_rB         <= R_NONE;
            D_valC       <= '0;
            D_valP       <= '0;
            E_stat       <= STAT_AOK;
            E_icode      <= I_NOP;
            E_ifun       <= 4'h0;
            E_valC       <= '0;
            E_valA       <= '0;
            E_valB       <= '0;
            E_dstE       <= R_NONE;
            E_dstM       <= R_NONE;
            E_srcA       <= R_NONE;
            E_srcB       <= R_NONE;
            stall_cnt    <= '0;
            bubble_cnt   <= '0;
            ctl_conflict <= 1'b0;
        end else begin
            if (!F_stall) begin
                F_predPC <= f_predPC;
            end

            // Stall outranks bubble so a conflicting request never loses the held instruction.
            if (D_stall) begin
                D_stat <= D_stat;
            end else if (D_bubble) begin
                D_stat  <= STAT_AOK;
                D_icode <= I_NOP;
                D_ifun  <= 4'h0;
                D_rA    <= R_NONE;
                D_rB    <= R_NONE;
                D_valC  <= '0;
                D_valP  <= '0;
            end else begin
                D_stat  <= f_stat;
                D_icode <= f_icode;
                D_ifun  <= f_ifun;
                D_rA    <= f_rA;
                D_rB    <= f_rB;
                D_valC  <= f_valC;
                D_valP  <= f_valP;
            end

            if (E_bubble) begin
                E_stat  <= STAT_AOK;
                E_icode <= I_NOP;
                E_ifun  <= 4'h0;
                E_valC  <= '0;
                E_valA  <= '0;
                E_valB  <= '0;
                E_dstE  <= R_NONE;
                E_dstM  <= R_NONE;
                E_srcA  <= R_NONE;
                E_srcB  <= R_NONE;
            end else begin
                E_stat  <= d_stat;
                E_icode <= d_icode;
                E_ifun  <= d_ifun;
                E_valC  <= d_valC;
                E_valA  <= d_valA;
                E_valB  <= d_valB;
                E_dstE  <= d_dstE;
                E_dstM  <= d_dstM;
                E_srcA  <= d_srcA;
                E_srcB  <= d_srcB;
            end

            if (D_stall && stall_cnt != cnt_max) begin
                stall_cnt <= stall_cnt + CW'(1);
            end
            if ((D_bubble || E_bubble) && bubble_cnt != cnt_max) begin
                bubble_cnt <= bubble_cnt + CW'(1);
            end
            if (D_stall && D_bubble) begin
                ctl_conflict <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_regs.sv
// Directed self-checking bench for pipe_regs, built with CW=4 so counter saturation is reachable.
module tb_pipe_regs;

    localparam int unsigned W  = 64;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          F_stall, D_stall, D_bubble, E_bubble;
    logic [W-1:0]  f_predPC, f_valC, f_valP;
    logic [1:0]    f_stat, d_stat;
    logic [3:0]    f_icode, f_ifun, f_rA, f_rB;
    logic [3:0]    d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
    logic [W-1:0]  d_valC, d_valA, d_valB;
    logic [W-1:0]  F_predPC, D_valC, D_valP, E_valC, E_valA, E_valB;
    logic [1:0]    D_stat, E_stat;
    logic [3:0]    D_icode, D_ifun, D_rA, D_rB;
    logic [3:0]    E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [CW-1:0] stall_cnt, bubble_cnt;
    logic          ctl_conflict;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_regs #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .f_predPC(f_predPC), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
        .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC),
        .d_valA(d_valA), .d_valB(d_valB), .d_dstE(d_dstE), .d_dstM(d_dstM),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .F_predPC(F_predPC), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .ctl_conflict(ctl_conflict)
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; controls cleared so the next edge loads normally.
    task automatic do_reset();
        F_stall = 0; D_stall = 0; D_bubble = 0; E_bubble = 0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        f_icode = 4'h6; f_predPC = 64'h40; d_dstM = 4'h2;
        step();
        // Assert reset mid-cycle, well before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (D_icode !== 4'h1) $display("FAIL reset_D_icode got %h want 1", D_icode);
        else n_pass++;
        n_total++;
        if (E_dstM !== 4'hF) $display("FAIL reset_E_dstM got %h want f", E_dstM);
        else n_pass++;
        n_total++;
        if (F_predPC !== 64'h0) $display("FAIL reset_F_predPC got %h want 0", F_predPC);
        else n_pass++;
        n_total++;
        if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0 || ctl_conflict !== 1'b0)
            $display("FAIL reset_counters got %0d/%0d/%b want 0/0/0",
                     stall_cnt, bubble_cnt, ctl_conflict);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_normal();
        do_reset();
        f_icode = 4'h6; f_rA = 4'h2; f_valP = 64'h10;
        step();
        n_total++;
        if (D_icode !== 4'h6 || D_rA !== 4'h2 || D_valP !== 64'h10)
            $display("FAIL normal_D got %h/%h/%h want 6/2/10", D_icode, D_rA, D_valP);
        else n_pass++;
        d_icode = 4'h6; d_dstE = 4'h3; d_valA = 64'h1234;
        step();
        n_total++;
        if (E_icode !== 4'h6 || E_dstE !== 4'h3 || E_valA !== 64'h1234)
            $display("FAIL normal_E got %h/%h/%h want 6/3/1234", E_icode, E_dstE, E_valA);
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        f_icode = 4'h6;
        step();
        f_icode = 4'h2; d_icode = 4'h6; d_srcA = 4'h1;
        D_stall = 1; E_bubble = 1;
        step();
        D_stall = 0; E_bubble = 0;
        n_total++;
        if (D_icode !== 4'h6) $display("FAIL loaduse_D_hold got %h want 6", D_icode);
        else n_pass++;
        n_total++;
        if (E_icode !== 4'h1 || E_srcA !== 4'hF)
            $display("FAIL loaduse_E_bubble got %h/%h want 1/f", E_icode, E_srcA);
        else n_pass++;
        n_total++;
        if (stall_cnt !== 4'd1 || bubble_cnt !== 4'd1)
            $display("FAIL loaduse_cnt got %0d/%0d want 1/1", stall_cnt, bubble_cnt);
        else n_pass++;
        step();
        n_total++;
        if (D_icode !== 4'h2 || E_icode !== 4'h6)
            $display("FAIL loaduse_resume got %h/%h want 2/6", D_icode, E_icode);
        else n_pass++;
    endtask

    task automatic test_ret();
        do_reset();
        f_icode = 4'h9; f_rB = 4'h4; f_valC = 64'hABCD;
        D_bubble = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (D_icode !== 4'h1 || D_rB !== 4'hF || D_valC !== 64'h0)
                $display("FAIL ret_bubble%0d got %h/%h/%h want 1/f/0", i, D_icode, D_rB, D_valC);
            else n_pass++;
        end
        D_bubble = 0;
        n_total++;
        if (bubble_cnt !== 4'd3) $display("FAIL ret_bubble_cnt got %0d want 3", bubble_cnt);
        else n_pass++;
        step();
        n_total++;
        if (D_icode !== 4'h9 || D_valC !== 64'hABCD)
            $display("FAIL ret_resume got %h/%h want 9/abcd", D_icode, D_valC);
        else n_pass++;
    endtask

    task automatic test_conflict();
        do_reset();
        f_icode = 4'h6;
        step();
        f_icode = 4'h3;
        D_stall = 1; D_bubble = 1; E_bubble = 1;
        step();
        D_stall = 0; D_bubble = 0; E_bubble = 0;
        n_total++;
        if (D_icode !== 4'h6 || ctl_conflict !== 1'b1)
            $display("FAIL conflict_hold got %h/%b want 6/1", D_icode, ctl_conflict);
        else n_pass++;
        n_total++;
        if (stall_cnt !== 4'd1 || bubble_cnt !== 4'd1)
            $display("FAIL conflict_cnt got %0d/%0d want 1/1", stall_cnt, bubble_cnt);
        else n_pass++;
        step();
        n_total++;
        if (ctl_conflict !== 1'b1 || D_icode !== 4'h3)
            $display("FAIL conflict_sticky got %b/%h want 1/3", ctl_conflict, D_icode);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (ctl_conflict !== 1'b0) $display("FAIL conflict_clear got %b want 0", ctl_conflict);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        do_reset();
        f_predPC = 64'h100; f_icode = 4'h7;
        step();
        f_predPC = 64'h200; f_icode = 4'h8;
        F_stall = 1; D_stall = 1; E_bubble = 1;
        for (int i = 0; i < 20; i++) step();
        n_total++;
        if (stall_cnt !== 4'd15) $display("FAIL sat_stall_cnt got %0d want 15", stall_cnt);
        else n_pass++;
        n_total++;
        if (bubble_cnt !== 4'd15) $display("FAIL sat_bubble_cnt got %0d want 15", bubble_cnt);
        else n_pass++;
        n_total++;
        if (F_predPC !== 64'h100 || D_icode !== 4'h7)
            $display("FAIL sat_hold got %h/%h want 100/7", F_predPC, D_icode);
        else n_pass++;
        // Reset while still stalling: held values must not survive.
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (F_predPC !== 64'h0 || D_icode !== 4'h1 || stall_cnt !== 4'd0)
            $display("FAIL sat_midstall_reset got %h/%h/%0d want 0/1/0",
                     F_predPC, D_icode, stall_cnt);
        else n_pass++;
        rst_n = 1'b1;
        F_stall = 0; D_stall = 0; E_bubble = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        F_stall = 0; D_stall = 0; D_bubble = 0; E_bubble = 0;
        f_predPC = '0; f_stat = 2'd0; f_icode = 4'h0; f_ifun = 4'h0;
        f_rA = 4'hF; f_rB = 4'hF; f_valC = '0; f_valP = '0;
        d_stat = 2'd0; d_icode = 4'h0; d_ifun = 4'h0; d_valC = '0; d_valA = '0; d_valB = '0;
        d_dstE = 4'hF; d_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
        #2;
        rst_n = 1'b1;
        test_reset();
        test_normal();
        test_load_use();
        test_ret();
        test_conflict();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_regs.md
# pipe_regs

Pipeline-register bank for the Y86-64 five-stage core: the F (predicted PC), D (fetch→decode) and E (decode→execute) registers. It is the consumer of the stall/bubble controls produced by the hazard-control logic. On each clock it either loads the upstream stage values, holds them (stall), or injects a nop bubble. It also keeps saturating hazard-event counters and a sticky conflict flag for debug.

## Interface
Parameters
- `W`, default 64, data/address width for PC, valC, valP, valA and valB.
- `CW`, default 32, width of the hazard-event counters.

Ports
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `F_stall` in 1: hold F_predPC.
- `D_stall` in 1: hold the D register.
- `D_bubble` in 1: load a bubble into the D register.
- `E_bubble` in 1: load a bubble into the E register.
- `f_predPC` in W: next predicted PC.
- `f_stat` in 2, `f_icode` in 4, `f_ifun` in 4, `f_rA` in 4, `f_rB` in 4, `f_valC` in W, `f_valP` in W: fetch outputs.
- `d_stat` in 2, `d_icode` in 4, `d_ifun` in 4, `d_valC` in W, `d_valA` in W, `d_valB` in W, `d_dstE` in 4, `d_dstM` in 4, `d_srcA` in 4, `d_srcB` in 4: decode outputs.
- `F_predPC` out W: registered predicted PC.
- `D_stat`, `D_icode`, `D_ifun`, `D_rA`, `D_rB`, `D_valC`, `D_valP` out: registered D fields, same widths as the f_ inputs.
- `E_stat`, `E_icode`, `E_ifun`, `E_valC`, `E_valA`, `E_valB`, `E_dstE`, `E_dstM`, `E_srcA`, `E_srcB` out: registered E fields, same widths as the d_ inputs.
- `stall_cnt` out CW: number of cycles with D_stall=1.
- `bubble_cnt` out CW: number of cycles with D_bubble=1 or E_bubble=1.
- `ctl_conflict` out 1: sticky; set when D_stall and D_bubble are both 1 in one cycle.

## Operation
- Stat encoding: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- Bubble contents, applied to a whole register:
  - stat=AOK, icode=4'h1 (nop), ifun=0.
  - All register IDs (rA, rB, dstE, dstM, srcA, srcB) = 4'hF (none).
  - valC, valP, valA, valB = 0.
- F register:
  - F_stall=1: hold.
  - Otherwise: load f_predPC.
- D register, per rising edge, highest priority first:
  - D_stall=1: hold all D fields.
  - D_bubble=1: load bubble contents.
  - Otherwise: load the f_ fields.
  - If D_stall and D_bubble are both 1, stall wins and ctl_conflict is set.
- E register:
  - E_bubble=1: load bubble contents.
  - Otherwise: load the d_ fields.
  - E has no stall input. The load-use case is D_stall=1 together with E_bubble=1: D holds, E bubbles.
- Counters:
  - stall_cnt increments by 1 on each edge where D_stall=1.
  - bubble_cnt increments by 1 on each edge where D_bubble|E_bubble=1. D and E bubbling in the same cycle counts once.
  - Both counters saturate at 2^CW−1 and do not wrap.
- ctl_conflict: set on the first conflicting edge and held until reset.
- Control inputs are sampled only at the rising edge; all outputs are registered. No combinational path runs from any input to any output.

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately without waiting for clk):
  - F_predPC=0.
  - D and E registers = bubble contents.
  - stall_cnt=0, bubble_cnt=0, ctl_conflict=0.
- Reset release: the first active edge is the first rising clk with rst_n=1. Inputs at that edge load normally.
- Latency: 1 cycle from an f_/d_ input to the matching D_/E_ output.
- Stall: D_stall held for N consecutive edges keeps the D outputs unchanged for N cycles. The edge after D_stall drops loads the f_ values present at that edge.
- Bubble: a single-edge pulse. The register shows nop for exactly one cycle unless the bubble is reasserted.
- Reset asserted mid-stall or mid-bubble: state immediately becomes the reset values. No held value survives reset.
- Counters at saturation: both stay at 2^CW−1 under continued events. With CW=4 the ceiling is 15.

## Test plan
- Reset: drive rst_n=0 mid-cycle with clk idle → outputs change immediately: D_icode=4'h1, E_dstM=4'hF, F_predPC=0, counters=0.
- Normal flow: f_icode=4'h6, f_rA=2, f_valP=0x10 at edge k → D_icode=6, D_rA=2, D_valP=0x10 after edge k. d_icode=6, d_dstE=3 → E_dstE=3 after the next edge.
- Load-use: D_stall=1, E_bubble=1 for one edge with D holding icode 4'h6 → D unchanged, E_icode=4'h1, E_srcA=4'hF. stall_cnt=1, bubble_cnt=1.
- ret handling: D_bubble=1 for 3 consecutive edges → D_icode=4'h1 for 3 cycles, bubble_cnt=3. The next edge loads f_icode.
- Conflict: D_stall=1 and D_bubble=1 together → D holds, ctl_conflict=1. ctl_conflict stays 1 after the controls clear and returns to 0 only on rst_n=0.
- Saturation: with CW=4, hold D_stall=1 for 20 edges → stall_cnt=15. F_stall=1 over the same edges → F_predPC unchanged.
